// File: rtl/reg_rename_file_pkg.sv
// Shared widths and helpers for the rename register file and its read ports.
package reg_rename_file_pkg;

  localparam int DEFAULT_REG_COUNT    = 32;
  localparam int DEFAULT_REG_ID_WIDTH = 5;
  localparam int DEFAULT_ROB_ID_WIDTH = 5;
  localparam int DEFAULT_XLEN         = 32;

  // Result of a source-operand lookup: how a read port resolved its register.
  typedef enum logic [1:0] {
    SRC_ZERO     = 2'd0,  // x0
    SRC_STORED   = 2'd1,  // committed value (possibly bypassed)
    SRC_BYPASS   = 2'd2,  // renamed, but the producer commits this cycle
    SRC_PENDING  = 2'd3   // waiting on a ROB entry
  } src_kind_e;

endpackage

// File: rtl/reg_rename_file_read_port.sv
// One source-operand read port: resolves a register to either a ready value
// or the ROB tag that will produce it, including same-cycle commit bypass.
module reg_read_port
  import reg_rename_file_pkg::*;
#(
  parameter int REG_ID_WIDTH = DEFAULT_REG_ID_WIDTH,
  parameter int ROB_ID_WIDTH = DEFAULT_ROB_ID_WIDTH,
  parameter int XLEN         = DEFAULT_XLEN
) (
  input  logic [REG_ID_WIDTH-1:0] rs,
  input  logic [ROB_ID_WIDTH-1:0] tag_at_rs,
  input  logic [XLEN-1:0]         value_at_rs,
  input  logic [ROB_ID_WIDTH-1:0] dest_from_rob,
  input  logic [REG_ID_WIDTH-1:0] rd_from_rob,
  input  logic [XLEN-1:0]         value_from_rob,
  output logic [ROB_ID_WIDTH-1:0] q,
  output logic [XLEN-1:0]         v
);

  src_kind_e kind;
  logic      commit_hits_rs;

  assign commit_hits_rs = (dest_from_rob != '0) && (rd_from_rob == rs);

  // Classify the source, then drive tag/value from the classification.
  always_comb begin
    kind = SRC_PENDING;
    if (rs == '0)
      kind = SRC_ZERO;
    else if (tag_at_rs == '0)
      kind = SRC_STORED;
    else if (commit_hits_rs && (dest_from_rob == tag_at_rs))
      kind = SRC_BYPASS;

    q = '0;
    v = '0;
    case (kind)
      SRC_ZERO:    ;
      SRC_STORED:  v = commit_hits_rs ? value_from_rob : value_at_rs;
      SRC_BYPASS:  v = value_from_rob;
      SRC_PENDING: q = tag_at_rs;
      default:     ;
    endcase
  end

endmodule

// File: rtl/reg_rename_file.sv
// Architectural register file with rename tags: issue records a new producer
// tag, commit retires a value (clearing the tag only if it is still the
// youngest rename), flush drops every rename.
module reg_rename_file
  import reg_rename_file_pkg::*;
#(
  parameter int REG_COUNT    = DEFAULT_REG_COUNT,
  parameter int REG_ID_WIDTH = DEFAULT_REG_ID_WIDTH,
  parameter int ROB_ID_WIDTH = DEFAULT_ROB_ID_WIDTH,
  parameter int XLEN         = DEFAULT_XLEN
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic                    reset_from_rob_bus,
  input  logic                    valid_from_issuer,
  input  logic [REG_ID_WIDTH-1:0] rd_from_issuer,
  input  logic [ROB_ID_WIDTH-1:0] dest_from_issuer,
  input  logic [REG_ID_WIDTH-1:0] rs1_from_issuer,
  input  logic [REG_ID_WIDTH-1:0] rs2_from_issuer,
  output logic [ROB_ID_WIDTH-1:0] qj_to_issuer,
  output logic [XLEN-1:0]         vj_to_issuer,
  output logic [ROB_ID_WIDTH-1:0] qk_to_issuer,
  output logic [XLEN-1:0]         vk_to_issuer,
  input  logic [ROB_ID_WIDTH-1:0] dest_from_rob,
  input  logic [REG_ID_WIDTH-1:0] rd_from_rob,
  input  logic [XLEN-1:0]         value_from_rob
);

  // Entry 0 is never written (all writes require rd != 0) and never read
  // (read ports short-circuit rs == 0), so it reduces to a constant.
  logic [XLEN-1:0]         value_reg [REG_COUNT];
  logic [ROB_ID_WIDTH-1:0] tag_reg   [REG_COUNT];

  logic commit_en;
  logic issue_en;

  assign commit_en = (dest_from_rob != '0) && (rd_from_rob != '0);
  assign issue_en  = valid_from_issuer && (rd_from_issuer != '0) && !reset_from_rob_bus;

  // State update: commit first, then flush or issue so issue wins the tag.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        value_reg[i] <= '0;
        tag_reg[i]   <= '0;
      end
    end else if (rdy) begin
      if (commit_en) begin
        value_reg[rd_from_rob] <= value_from_rob;
        if (tag_reg[rd_from_rob] == dest_from_rob)
          tag_reg[rd_from_rob] <= '0;
      end
      if (reset_from_rob_bus) begin
        for (int i = 0; i < REG_COUNT; i++)
          tag_reg[i] <= '0;
      end else if (issue_en) begin
        tag_reg[rd_from_issuer] <= dest_from_issuer;
      end
    end
  end

  logic [REG_ID_WIDTH-1:0] rs_sel   [2];
  logic [ROB_ID_WIDTH-1:0] q_port   [2];
  logic [XLEN-1:0]         v_port   [2];

  assign rs_sel[0] = rs1_from_issuer;
  assign rs_sel[1] = rs2_from_issuer;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_read
      reg_read_port #(
        .REG_ID_WIDTH (REG_ID_WIDTH),
        .ROB_ID_WIDTH (ROB_ID_WIDTH),
        .XLEN         (XLEN)
      ) u_port (
        .rs             (rs_sel[gi]),
        .tag_at_rs      (tag_reg[rs_sel[gi]]),
        .value_at_rs    (value_reg[rs_sel[gi]]),
        .dest_from_rob  (dest_from_rob),
        .rd_from_rob    (rd_from_rob),
        .value_from_rob (value_from_rob),
        .q              (q_port[gi]),
        .v              (v_port[gi])
      );
    end
  endgenerate

  assign qj_to_issuer = q_port[0];
  assign vj_to_issuer = v_port[0];
  assign qk_to_issuer = q_port[1];
  assign vk_to_issuer = v_port[1];

endmodule
